// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard unit: forwarding, stall/flush control, redirect tracker, perf counters
module hazard_ctrl #(
  parameter int CNT_W = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             perf_clr,
  input  logic [AW-1:0]    RA1D,
  input  logic [AW-1:0]    RA2D,
  input  logic [AW-1:0]    RA1E,
  input  logic [AW-1:0]    RA2E,
  input  logic [AW-1:0]    WA3E,
  input  logic [AW-1:0]    WA3M,
  input  logic [AW-1:0]    WA3W,
  input  logic             MemtoRegE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] redir_cnt,
  output logic             redir_err,
  output logic [1:0]       trk_state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    TE   = 2'b01,
    TM   = 2'b10,
    TW   = 2'b11
  } trk_t;

  trk_t             state_q, state_d;
  logic             err_set;
  logic             err_q;
  logic [CNT_W-1:0] stall_q, flush_q, redir_q;
  logic             ldrstall;
  logic             pcpend;

  // Operand forwarding: the younger producer in Memory beats Writeback.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RA1E == WA3M))      ForwardAE = 2'b10;
    else if (RegWriteW && (RA1E == WA3W)) ForwardAE = 2'b01;
    if (RegWriteM && (RA2E == WA3M))      ForwardBE = 2'b10;
    else if (RegWriteW && (RA2E == WA3W)) ForwardBE = 2'b01;
  end

  // Load-use stall and PC-write flush controls, no registering.
  always_comb begin
    ldrstall = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
    pcpend   = PCSrcD || PCSrcE || PCSrcM;
    StallF   = ldrstall || pcpend;
    StallD   = ldrstall;
    FlushD   = pcpend || PCSrcW || BranchTakenE;
    FlushE   = ldrstall || BranchTakenE;
  end

  // Tracker state register; reset abandons any in-flight redirect silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Tracker next state: follow an accepted PC writer down to Writeback.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: if (PCSrcD && !FlushE) state_d = TE;
      TE:   state_d = PCSrcE ? TM : IDLE;
      TM: begin
        if (PCSrcM) state_d = TW;
        else begin
          state_d = IDLE;
          err_set = 1'b1;
        end
      end
      TW: begin
        state_d = IDLE;
        err_set = !PCSrcW;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky error flag; a clear wins over a same-cycle failure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         err_q <= 1'b0;
    else if (perf_clr) err_q <= 1'b0;
    else if (err_set)  err_q <= 1'b1;
  end

  // Saturating event counters; clear has priority over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
      redir_q <= '0;
    end else if (perf_clr) begin
      stall_q <= '0;
      flush_q <= '0;
      redir_q <= '0;
    end else begin
      if (ldrstall && (stall_q != '1))          stall_q <= stall_q + CNT_W'(1);
      if ((FlushD || FlushE) && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
      if (PCSrcW && (redir_q != '1))            redir_q <= redir_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign redir_cnt = redir_q;
  assign redir_err = err_q;
  assign trk_state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl with a behavioural model
module tb_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int AW    = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 0, reset = 1, perf_clr = 0;
  logic [AW-1:0] RA1D = 0, RA2D = 0, RA1E = 0, RA2E = 0, WA3E = 0, WA3M = 0, WA3W = 0;
  logic MemtoRegE = 0, RegWriteM = 0, RegWriteW = 0;
  logic PCSrcD = 0, PCSrcE = 0, PCSrcM = 0, PCSrcW = 0, BranchTakenE = 0;
  logic [1:0] ForwardAE, ForwardBE, trk_state;
  logic StallF, StallD, FlushD, FlushE, redir_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, redir_cnt;

  int checks = 0, failures = 0;
  bit chk_en = 0;

  hazard_ctrl #(.CNT_W(CNT_W), .AW(AW)) dut (
    .clk(clk), .reset(reset), .perf_clr(perf_clr),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .redir_cnt(redir_cnt),
    .redir_err(redir_err), .trk_state(trk_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counts as plain integers, tracker as "stages still to reach"
  int  m_stall = 0, m_flush = 0, m_redir = 0;
  bit  m_err = 0;
  int  m_age = 0;   // 0: nothing tracked; k: tracked writer should now be in stage k (1=E,2=M,3=W)

  function automatic int m_fwd(input logic [AW-1:0] ra);
    if (RegWriteM && ra == WA3M) return 2;
    if (RegWriteW && ra == WA3W) return 1;
    return 0;
  endfunction

  function automatic bit m_ld();
    return MemtoRegE && (WA3E == RA1D || WA3E == RA2D);
  endfunction

  function automatic bit m_pend();
    return PCSrcD || PCSrcE || PCSrcM;
  endfunction

  function automatic bit m_fle();
    return m_ld() || BranchTakenE;
  endfunction

  function automatic bit m_fld();
    return m_pend() || PCSrcW || BranchTakenE;
  endfunction

  always @(posedge reset) begin
    m_stall = 0; m_flush = 0; m_redir = 0; m_err = 0; m_age = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_stall = 0; m_flush = 0; m_redir = 0; m_err = 0; m_age = 0;
    end else begin
      bit fail;
      bit [3:0] stage_bits;
      stage_bits = {PCSrcW, PCSrcM, PCSrcE, PCSrcD};
      fail = 0;
      if (m_age == 0) begin
        if (PCSrcD && !m_fle()) m_age = 1;
      end else if (stage_bits[m_age]) begin
        m_age = (m_age == 3) ? 0 : m_age + 1;
      end else begin
        fail = (m_age >= 2);
        m_age = 0;
      end
      if (perf_clr) begin
        m_stall = 0; m_flush = 0; m_redir = 0; m_err = 0;
      end else begin
        if (m_ld()) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
        if (m_fld() || m_fle()) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
        if (PCSrcW) m_redir = (m_redir < SAT) ? m_redir + 1 : SAT;
        if (fail) m_err = 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ForwardAE", ForwardAE, m_fwd(RA1E));
      chk("ForwardBE", ForwardBE, m_fwd(RA2E));
      chk("StallF", StallF, int'(m_ld() || m_pend()));
      chk("StallD", StallD, int'(m_ld()));
      chk("FlushD", FlushD, int'(m_fld()));
      chk("FlushE", FlushE, int'(m_fle()));
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
      chk("redir_cnt", redir_cnt, m_redir);
      chk("redir_err", redir_err, int'(m_err));
      chk("trk_state", trk_state, m_age);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 4'hF; WA3M = 0; WA3W = 0;
    MemtoRegE = 0; RegWriteM = 0; RegWriteW = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchTakenE = 0; perf_clr = 0;
  endtask

  task automatic clear_cycle();
    idle_inputs();
    perf_clr = 1;
    tick();
    perf_clr = 0;
  endtask

  initial begin
    bit pd, pe, pm;
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    chk_en = 1;
    chk("rst stall_cnt", stall_cnt, 0);
    chk("rst trk_state", trk_state, 0);
    chk("rst redir_err", redir_err, 0);

    // forwarding priority
    RA1E = 3; WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1; #1;
    chk("fwd M", ForwardAE, 2);
    RegWriteM = 0; #1;
    chk("fwd W", ForwardAE, 1);
    RegWriteW = 0; #1;
    chk("fwd none", ForwardAE, 0);

    // single load-use stall
    clear_cycle();
    MemtoRegE = 1; WA3E = 5; RA2D = 5; #1;
    chk("ld StallF", StallF, 1);
    chk("ld StallD", StallD, 1);
    chk("ld FlushE", FlushE, 1);
    tick();
    idle_inputs();
    chk("ld stall_cnt", stall_cnt, 1);
    chk("ld flush_cnt", flush_cnt, 1);

    // clean redirect through all stages
    clear_cycle();
    PCSrcD = 1; #1;
    chk("rd D trk", trk_state, 0);
    chk("rd D StallF", StallF, 1);
    tick(); PCSrcD = 0; PCSrcE = 1; #1;
    chk("rd E trk", trk_state, 1);
    tick(); PCSrcE = 0; PCSrcM = 1; #1;
    chk("rd M trk", trk_state, 2);
    chk("rd M StallF", StallF, 1);
    tick(); PCSrcM = 0; PCSrcW = 1; #1;
    chk("rd W trk", trk_state, 3);
    chk("rd W StallF", StallF, 0);
    chk("rd W FlushD", FlushD, 1);
    tick(); PCSrcW = 0; #1;
    chk("rd end trk", trk_state, 0);
    chk("rd redir_cnt", redir_cnt, 1);
    chk("rd flush_cnt", flush_cnt, 4);
    chk("rd redir_err", redir_err, 0);

    // writer lost between E and M
    clear_cycle();
    PCSrcD = 1; tick();
    PCSrcD = 0; PCSrcE = 1; tick();
    PCSrcE = 0; tick();
    chk("err set", redir_err, 1);
    tick();
    chk("err sticky", redir_err, 1);
    perf_clr = 1; tick(); perf_clr = 0;
    chk("clr err", redir_err, 0);
    chk("clr flush_cnt", flush_cnt, 0);

    // saturation
    clear_cycle();
    MemtoRegE = 1; WA3E = 5; RA2D = 5;
    repeat (15) tick();
    chk("sat 15", stall_cnt, 15);
    repeat (3) tick();
    chk("sat hold", stall_cnt, 15);
    perf_clr = 1; tick(); perf_clr = 0;
    chk("sat clr", stall_cnt, 0);

    // asynchronous reset while in TM
    clear_cycle();
    PCSrcD = 1; tick();
    PCSrcD = 0; PCSrcE = 1; tick();
    PCSrcE = 0; PCSrcM = 1;
    chk("pre-rst trk", trk_state, 2);
    #1 reset = 1; #1;
    chk("async trk", trk_state, 0);
    chk("async flush_cnt", flush_cnt, 0);
    chk("async err", redir_err, 0);
    tick();
    idle_inputs();
    reset = 0;
    tick(); tick();
    chk("post-rst err", redir_err, 0);
    chk("post-rst trk", trk_state, 0);

    // randomized traffic with a loosely pipelined PC writer stream
    pd = 0; pe = 0; pm = 0;
    for (int i = 0; i < 3000; i++) begin
      RA1D = AW'($urandom_range(0, 3)); RA2D = AW'($urandom_range(0, 3));
      RA1E = AW'($urandom_range(0, 3)); RA2E = AW'($urandom_range(0, 3));
      WA3E = AW'($urandom_range(0, 3)); WA3M = AW'($urandom_range(0, 3));
      WA3W = AW'($urandom_range(0, 3));
      MemtoRegE = ($urandom % 4) == 0;
      RegWriteM = $urandom % 2; RegWriteW = $urandom % 2;
      BranchTakenE = ($urandom % 8) == 0;
      perf_clr = ($urandom % 40) == 0;
      PCSrcW = pm && (($urandom % 8) != 0);
      PCSrcM = pe && (($urandom % 8) != 0);
      PCSrcE = pd && (($urandom % 6) != 0);
      PCSrcD = ($urandom % 5) == 0;
      pd = PCSrcD; pe = PCSrcE; pm = PCSrcM;
      tick();
    end

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
